// File: rtl/dds_axis_gen.sv
// -----------------------------------------------------------------------------
// dds_axis_gen
// Multi-waveform direct digital synthesiser with AXI-Stream interfaces.
// A phase accumulator feeds a 4-stage pipeline that produces sine
// (quarter-wave ROM), square, triangle or sawtooth samples. The sample and
// its phase leave on two lock-stepped AXI-Stream masters.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_config_*        config slave {resync, mode[1:0], poff, pinc}
//   m_axis_data_*          signed sample stream (DATA_W bits)
//   m_axis_phase_*         phase used for the sample on the data channel
// -----------------------------------------------------------------------------
module dds_axis_gen #(
  parameter int                 PHASE_W   = 16,
  parameter int                 DATA_W    = 8,
  parameter int                 LUT_AW    = 8,
  parameter logic [PHASE_W-1:0] PINC_INIT = PHASE_W'(16'h0400),
  parameter logic [PHASE_W-1:0] POFF_INIT = {PHASE_W{1'b0}},
  parameter logic [1:0]         MODE_INIT = 2'd0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [2*PHASE_W+2:0]     s_axis_config_tdata,
  input  logic                     s_axis_config_tvalid,
  output logic                     s_axis_config_tready,
  output logic signed [DATA_W-1:0] m_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [PHASE_W-1:0]       m_axis_phase_tdata,
  output logic                     m_axis_phase_tvalid,
  input  logic                     m_axis_phase_tready
);

  localparam int                FX   = 30;
  localparam logic [DATA_W-1:0] PEAK = {1'b0, {(DATA_W-1){1'b1}}};

  // Quarter-wave sine magnitude for ROM entry idx, sampled at the bin centre.
  // Evaluated at elaboration with a fixed-point Taylor series (2^-30 scale)
  // so no real arithmetic reaches synthesis.
  function automatic int sin_q(input int idx);
    longint x, x2, term, sum;
    x    = (64'sd3373259426 * longint'(2 * idx + 1)) >>> (LUT_AW + 2);
    x2   = (x * x) >>> FX;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -(((term * x2) >>> FX) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    return int'((sum * longint'(2 ** (DATA_W - 1) - 1) + (64'sd1 <<< (FX - 1))) >>> FX);
  endfunction

  logic [DATA_W-1:0] w_rom [2**LUT_AW];

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
    localparam int ROM_V = sin_q(g);
    assign w_rom[g] = DATA_W'(ROM_V);
  end

  // Config and control state
  logic               r_cfg_rdy;
  logic [PHASE_W-1:0] r_acc, r_pinc, r_poff;
  logic [1:0]         r_mode;
  // Pipeline state
  logic               r_s1_vld, r_s2_vld, r_out_vld;
  logic [PHASE_W-1:0] r_s1_ph, r_s2_ph, r_out_ph;
  logic [1:0]         r_s1_mode;
  logic [DATA_W-1:0]  r_s2_data, r_out_data;

  logic               w_cfg_hs, w_resync, w_adv;
  logic [1:0]         w_cfg_mode, w_quad;
  logic [PHASE_W-1:0] w_cfg_poff, w_cfg_pinc, w_s0_ph;
  logic [LUT_AW-1:0]  w_lut_a, w_addr;
  logic [DATA_W-1:0]  w_mag, w_tri_t, w_wave;

  assign w_cfg_hs   = s_axis_config_tvalid & r_cfg_rdy;
  assign w_resync   = s_axis_config_tdata[2*PHASE_W+2];
  assign w_cfg_mode = s_axis_config_tdata[2*PHASE_W+1 -: 2];
  assign w_cfg_poff = s_axis_config_tdata[2*PHASE_W-1 -: PHASE_W];
  assign w_cfg_pinc = s_axis_config_tdata[PHASE_W-1:0];

  // The whole pipeline moves as one; it only stalls when a valid output
  // sample is waiting for either sink.
  assign w_adv   = ~r_out_vld | (m_axis_data_tready & m_axis_phase_tready);
  assign w_s0_ph = r_acc + r_poff;

  // Sine lookup: odd quadrants read the ROM mirrored, lower half is negated.
  assign w_quad  = r_s1_ph[PHASE_W-1 -: 2];
  assign w_lut_a = r_s1_ph[PHASE_W-3 -: LUT_AW];
  assign w_addr  = w_quad[0] ? ~w_lut_a : w_lut_a;
  assign w_mag   = w_rom[w_addr];
  // Triangle: fold the second half of the period back down.
  assign w_tri_t = r_s1_ph[PHASE_W-1] ? ~r_s1_ph[PHASE_W-2 -: DATA_W]
                                      : r_s1_ph[PHASE_W-2 -: DATA_W];

  // Waveform selection for the sample currently in stage 1.
  always_comb begin
    w_wave = {DATA_W{1'b0}};
    if (r_s1_vld) begin
      case (r_s1_mode)
        2'd0:    w_wave = w_quad[1] ? -w_mag : w_mag;
        2'd1:    w_wave = r_s1_ph[PHASE_W-1] ? -PEAK : PEAK;
        2'd2:    w_wave = {~w_tri_t[DATA_W-1], w_tri_t[DATA_W-2:0]};
        2'd3:    w_wave = {~r_s1_ph[PHASE_W-1], r_s1_ph[PHASE_W-2 -: DATA_W-1]};
        default: w_wave = {DATA_W{1'b0}};
      endcase
    end else begin
      w_wave = {DATA_W{1'b0}};
    end
  end

  // Config registers; the config port is never backpressured after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cfg_rdy <= 1'b0;
      r_pinc    <= PINC_INIT;
      r_poff    <= POFF_INIT;
      r_mode    <= MODE_INIT;
    end else begin
      r_cfg_rdy <= 1'b1;
      if (w_cfg_hs) begin
        r_pinc <= w_cfg_pinc;
        r_poff <= w_cfg_poff;
        r_mode <= w_cfg_mode;
      end
    end
  end

  // Phase accumulator; a resync clears it even while the pipeline is stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc <= {PHASE_W{1'b0}};
    end else if (w_cfg_hs && w_resync) begin
      r_acc <= {PHASE_W{1'b0}};
    end else if (w_adv) begin
      r_acc <= r_acc + r_pinc;
    end
  end

  // Sample pipeline S1..S3; each sample carries its own phase and mode.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_vld   <= 1'b0;
      r_s1_ph    <= {PHASE_W{1'b0}};
      r_s1_mode  <= 2'd0;
      r_s2_vld   <= 1'b0;
      r_s2_ph    <= {PHASE_W{1'b0}};
      r_s2_data  <= {DATA_W{1'b0}};
      r_out_vld  <= 1'b0;
      r_out_ph   <= {PHASE_W{1'b0}};
      r_out_data <= {DATA_W{1'b0}};
    end else if (w_adv) begin
      r_s1_vld   <= 1'b1;
      r_s1_ph    <= w_s0_ph;
      r_s1_mode  <= r_mode;
      r_s2_vld   <= r_s1_vld;
      r_s2_ph    <= r_s1_ph;
      r_s2_data  <= w_wave;
      r_out_vld  <= r_s2_vld;
      r_out_ph   <= r_s2_ph;
      r_out_data <= r_s2_data;
    end
  end

  assign s_axis_config_tready = r_cfg_rdy;
  assign m_axis_data_tdata    = r_out_data;
  assign m_axis_data_tvalid   = r_out_vld;
  assign m_axis_phase_tdata   = r_out_ph;
  assign m_axis_phase_tvalid  = r_out_vld;

endmodule

// File: tb/tb_dds_axis_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_axis_gen
// Self-checking bench for dds_axis_gen with default parameters. A reference
// model keeps the stream of (phase, mode) samples in a queue and derives the
// expected waveform value from the phase with plain arithmetic and $sin.
// -----------------------------------------------------------------------------
module tb_dds_axis_gen;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [34:0]       cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic signed [7:0] d_data;
  logic              d_valid;
  logic              d_ready;
  logic [15:0]       p_data;
  logic              p_valid;
  logic              p_ready;

  always #5 aclk = ~aclk;

  dds_axis_gen dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_config_tdata  (cfg_data),
    .s_axis_config_tvalid (cfg_valid),
    .s_axis_config_tready (cfg_ready),
    .m_axis_data_tdata    (d_data),
    .m_axis_data_tvalid   (d_valid),
    .m_axis_data_tready   (d_ready),
    .m_axis_phase_tdata   (p_data),
    .m_axis_phase_tvalid  (p_valid),
    .m_axis_phase_tready  (p_ready)
  );

  typedef struct packed {
    logic [15:0] ph;
    logic [1:0]  md;
  } samp_t;

  samp_t       q[$];
  logic [15:0] m_acc, m_pinc, m_poff;
  logic [1:0]  m_mode;
  logic        m_cfg_rdy;
  int          fill;
  int          checks = 0;
  int          failures = 0;

  function automatic logic signed [7:0] wave(input logic [15:0] ph, input logic [1:0] md);
    int v, idx;
    case (md)
      2'd0: begin
        idx = ph[14] ? 255 - int'(ph[13:6]) : int'(ph[13:6]);
        v = $rtoi(127.0 * $sin(2.0 * 3.141592653589793 * (real'(idx) + 0.5) / 1024.0) + 0.5);
        if (ph[15]) v = -v;
      end
      2'd1:    v = ph[15] ? -127 : 127;
      2'd2:    v = ph[15] ? 127 - int'(ph[14:7]) : -128 + int'(ph[14:7]);
      default: v = int'(ph[15:8]) - 128;
    endcase
    return v[7:0];
  endfunction

  function automatic logic exp_vld();
    return fill == 3;
  endfunction

  function automatic logic [15:0] exp_p();
    return (fill == 3) ? q[0].ph : 16'h0000;
  endfunction

  function automatic logic signed [7:0] exp_d();
    return (fill == 3) ? wave(q[0].ph, q[0].md) : 8'sh00;
  endfunction

  task automatic model_reset();
    m_acc = 16'h0000; m_pinc = 16'h0400; m_poff = 16'h0000; m_mode = 2'd0;
    m_cfg_rdy = 1'b0; fill = 0; q.delete();
  endtask

  // Advance one clock (called just after a falling edge) and update the model.
  task automatic tick();
    logic adv, xfer, hs;
    samp_t s;
    adv  = (fill < 3) || (d_ready && p_ready);
    xfer = (fill == 3) && d_ready && p_ready;
    hs   = cfg_valid && m_cfg_rdy;
    @(posedge aclk);
    if (xfer) void'(q.pop_front());
    if (adv) begin
      s.ph = m_acc + m_poff;
      s.md = m_mode;
      q.push_back(s);
      if (fill < 3) fill++;
    end
    if (hs && cfg_data[34]) m_acc = 16'h0000;
    else if (adv) m_acc = m_acc + m_pinc;
    if (hs) begin
      m_mode = cfg_data[33:32]; m_poff = cfg_data[31:16]; m_pinc = cfg_data[15:0];
    end
    m_cfg_rdy = 1'b1;
    @(negedge aclk);
  endtask

  task automatic send_cfg(input logic rs, input logic [1:0] md, input logic [15:0] poff,
                          input logic [15:0] pinc);
    cfg_data = {rs, md, poff, pinc};
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; cfg_valid = 1'b0; cfg_data = 35'd0; d_ready = 1'b1; p_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge aclk);
    checks++;
    if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== 27'd0) begin
      failures++;
      $display("FAIL reset got v=%b%b r=%b d=%0d p=%h expected all zero",
               d_valid, p_valid, cfg_ready, d_data, p_data);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_default();
    int nsamp = 0;
    for (int i = 0; i < 80; i++) begin
      checks++;
      if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== {exp_vld(), exp_vld(), m_cfg_rdy, exp_d(), exp_p()}) begin
        failures++;
        $display("FAIL default i=%0d got v=%b%b r=%b d=%0d p=%h exp v=%b r=%b d=%0d p=%h",
                 i, d_valid, p_valid, cfg_ready, d_data, p_data, exp_vld(), m_cfg_rdy, exp_d(), exp_p());
      end
      if (d_valid) begin
        checks++;
        if (p_data !== 16'(nsamp * 1024)) begin
          failures++;
          $display("FAIL default_seq n=%0d got p=%h expected %h", nsamp, p_data, 16'(nsamp * 1024));
        end
        if (p_data == 16'h4000 || p_data == 16'hC000 || p_data == 16'h0000) begin
          checks++;
          if ((p_data == 16'h4000 && d_data !== 8'sd127) || (p_data == 16'hC000 && d_data !== -8'sd127) ||
              (p_data == 16'h0000 && (d_data > 8'sd1 || d_data < -8'sd1))) begin
            failures++;
            $display("FAIL sine_anchor p=%h got d=%0d expected 127/-127/|x|<=1", p_data, d_data);
          end
        end
        nsamp++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 20; i++) begin
      d_ready = !(i >= 5 && i < 10);
      p_ready = 1'b1;
      checks++;
      if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== {exp_vld(), exp_vld(), m_cfg_rdy, exp_d(), exp_p()}) begin
        failures++;
        $display("FAIL backpressure i=%0d got v=%b%b r=%b d=%0d p=%h exp v=%b r=%b d=%0d p=%h",
                 i, d_valid, p_valid, cfg_ready, d_data, p_data, exp_vld(), m_cfg_rdy, exp_d(), exp_p());
      end
      tick();
    end
    d_ready = 1'b1;
  endtask

  // Runs n checked cycles after one config word; label names the scenario.
  task automatic test_config(input string label, input logic rs, input logic [1:0] md,
                             input logic [15:0] poff, input logic [15:0] pinc, input int n);
    send_cfg(rs, md, poff, pinc);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== {exp_vld(), exp_vld(), m_cfg_rdy, exp_d(), exp_p()}) begin
        failures++;
        $display("FAIL %s i=%0d got v=%b%b r=%b d=%0d p=%h exp v=%b r=%b d=%0d p=%h",
                 label, i, d_valid, p_valid, cfg_ready, d_data, p_data, exp_vld(), m_cfg_rdy, exp_d(), exp_p());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      p_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        cfg_valid = 1'b1;
        cfg_data = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom)};
      end else begin
        cfg_valid = 1'b0;
      end
      checks++;
      if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== {exp_vld(), exp_vld(), m_cfg_rdy, exp_d(), exp_p()}) begin
        failures++;
        $display("FAIL random i=%0d got v=%b%b r=%b d=%0d p=%h exp v=%b r=%b d=%0d p=%h",
                 i, d_valid, p_valid, cfg_ready, d_data, p_data, exp_vld(), m_cfg_rdy, exp_d(), exp_p());
      end
      tick();
    end
    cfg_valid = 1'b0; d_ready = 1'b1; p_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    d_ready = 1'b0;
    repeat (3) tick();
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset got v=%b%b r=%b d=%0d p=%h expected all zero without an edge",
               d_valid, p_valid, cfg_ready, d_data, p_data);
    end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    d_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({d_valid, p_valid, cfg_ready, d_data, p_data} !== {exp_vld(), exp_vld(), m_cfg_rdy, exp_d(), exp_p()}) begin
        failures++;
        $display("FAIL after_reset i=%0d got v=%b%b r=%b d=%0d p=%h exp v=%b r=%b d=%0d p=%h",
                 i, d_valid, p_valid, cfg_ready, d_data, p_data, exp_vld(), m_cfg_rdy, exp_d(), exp_p());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_backpressure();
    test_config("square_resync", 1'b1, 2'd1, 16'h0000, 16'h1000, 40);
    test_config("sawtooth", 1'b1, 2'd3, 16'h0000, 16'h0100, 270);
    test_config("triangle", 1'b1, 2'd2, 16'h8000, 16'h0200, 140);
    test_config("pinc_zero", 1'b0, 2'd0, 16'h1234, 16'h0000, 12);
    test_config("sine_fast", 1'b0, 2'd0, 16'h0000, 16'h0340, 90);
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_axis_gen.md
Name: dds_axis_gen

Overview:
- Parametrised, multi-waveform DDS core that replaces the fixed-width vendor DDS IP with in-house RTL.
- Phase accumulator feeds a quarter-wave sine ROM and arithmetic square/triangle/sawtooth generators.
- Output is two lock-stepped AXI-Stream masters (sample data, phase) with full tready backpressure.
- Frequency, phase offset, waveform and phase resync are runtime-programmable through an AXI-Stream config slave.

Parameters:
- PHASE_W, 16: accumulator/phase width; must be >= LUT_AW+2 and >= DATA_W+1.
- DATA_W, 8: output sample width, two's complement.
- LUT_AW, 8: quarter-wave sine ROM address width (2^LUT_AW entries).
- PINC_INIT, 16'h0400: phase increment after reset.
- POFF_INIT, 0: phase offset after reset.
- MODE_INIT, 0: waveform after reset (0 sine, 1 square, 2 triangle, 3 sawtooth).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_config_tdata  in  2*PHASE_W+3  {resync[1], mode[2], poff[PHASE_W], pinc[PHASE_W]}, MSB first.
- s_axis_config_tvalid  in  1  config word valid.
- s_axis_config_tready  out  1  config accept.
- m_axis_data_tdata  out  DATA_W  signed sample.
- m_axis_data_tvalid  out  1  sample valid.
- m_axis_data_tready  in  1  sample sink ready.
- m_axis_phase_tdata  out  PHASE_W  phase used for the sample on the data channel.
- m_axis_phase_tvalid  out  1  equals m_axis_data_tvalid.
- m_axis_phase_tready  in  1  phase sink ready.

Behaviour:
- Reset (async assert, sync release): acc=0; pinc/poff/mode = *_INIT; all pipeline valids 0; both tdata 0; both tvalid 0; s_axis_config_tready 0.
- s_axis_config_tready registers to 1 on the first edge after release and stays 1 (config is never backpressured).
- Config handshake (tvalid&tready) at edge k: pinc/poff/mode registers load at edge k. If resync=1, acc loads 0 at edge k instead of advancing, even if stalled.
- Pipeline enable: adv = ~out_valid | (m_axis_data_tready & m_axis_phase_tready). When adv=0, acc and every stage hold. The source is always valid, so the pipeline carries no bubbles after fill.
- S0: acc <= acc + pinc, mod 2^PHASE_W. ph = acc + poff, mod 2^PHASE_W.
- S1: registers ph, mode, valid=1.
- S2: waveform compute, registered with ph, mode and valid.
- S3: output registers drive both tdata and the shared tvalid.
- Latency: the first tvalid=1 occurs on the 3rd rising edge after the first edge with aresetn high. The first sample phase is POFF_INIT, then POFF_INIT+PINC_INIT, and so on.
- Mode is captured with each sample. In-flight samples keep their mode; a new pinc/mode affects only samples whose S0 occurs after the config edge.
- Sine: q = ph[PW-1:PW-2]; a = ph[PW-3 -: LUT_AW].
  - Address = a for q=0/2, ~a for q=1/3.
  - Output is negated for q=2/3.
  - ROM[i] = round((2^(DATA_W-1)-1) * sin(2π(i+0.5)/2^(LUT_AW+2))), computed at elaboration.
- Square: ph MSB=0 gives +(2^(DATA_W-1)-1); MSB=1 gives -(2^(DATA_W-1)-1).
- Sawtooth: s = ph[PW-1 -: DATA_W] with MSB inverted; ramps -2^(D-1) to 2^(D-1)-1 and wraps once per period.
- Triangle: t = ph[PW-2 -: DATA_W], bitwise inverted when ph MSB=1, then MSB inverted to signed. Peaks at ph=0x8000 (default widths).
- AXI rules:
  - tvalid never depends on tready.
  - tdata/tvalid are stable while tvalid=1 and a transfer is pending.
  - A transfer completes only when both sinks are ready.
  - No sample is dropped or duplicated.
- pinc=0 is legal: constant output at phase poff.
- Accumulator wrap is silent modulo arithmetic.
- Reset asserted mid-operation clears outputs immediately (asynchronously). Pending samples are discarded.

Test Plan:
- Reset, defaults, both ready=1 -> phase tdata 0x0000,0x0400,0x0800,... (period 64 samples). Data is +127 at phase 0x4000, -127 at 0xC000, and |x|<=1 at 0x0000.
- data_tready=0 for 5 cycles mid-stream, phase_tready=1 -> both channels hold the same tdata and tvalid stays 1. After release, the phase sequence continues with no gap or repeat.
- Config {resync=1, mode=1, poff=0, pinc=0x1000} -> after the 3-sample pipeline drain, output is 8 samples of +127 then 8 of -127, repeating, with phase restarting at 0x0000.
- Config mode=3, pinc=0x0100 -> samples -128,-127,...,+127, then wrap to -128, for 256 samples per period.
- Config mode=2, pinc=0x0200, poff=0x8000 -> the first post-resync sample is +127 (approximately), falling to about -128 at phase 0x0000.
- aresetn pulsed low mid-stream while tready=0 -> tvalid and tdata go to 0 without a clock edge. After release, the sequence restarts at POFF_INIT and config tready returns to 1 one cycle later.
